memory_word_controller: RTL
===========================

// Module: memory_word_controller
// PURPOSE
//  Sequences the byte-wide 2048x8 synchronous RAM (1-cycle registered read, write-enable port)
//  into a 32-bit RV32 load/store port (LB/LH/LW/LBU/LHU/SB/SH/SW).
//  Sits between the core's load/store unit and one RAM instance; one request in flight at a time.
//  Little-endian byte order; accesses are split into 1/2/4 sequential byte cycles.
// PARAMETERS
//  ADDR_WIDTH  11  RAM byte-address width; addresses wrap modulo 2**ADDR_WIDTH
// PORTS
//  clk                input   1           rising-edge clock
//  reset              input   1           synchronous, active-high reset
//  req_valid          input   1           request present
//  req_ready          output  1           controller idle; request accepted when valid & ready
//  req_write          input   1           1 = store, 0 = load
//  req_funct3         input   3           RV32 funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU (loads); 0/1/2 (stores)
//  req_addr           input   32          byte address; only [ADDR_WIDTH-1:0] used
//  req_wdata          input   32          store data, low bytes used per size
//  rsp_valid          output  1           one-cycle completion pulse (no backpressure)
//  rsp_rdata          output  32          load result, extended; 0 for stores/errors
//  rsp_error          output  1           qualified by rsp_valid
//  mem_write_enable   output  1           to RAM
//  mem_write_address  output  ADDR_WIDTH  to RAM
//  mem_write_data     output  8           to RAM
//  mem_read_address   output  ADDR_WIDTH  to RAM
//  mem_read_data      input   8           from RAM, valid the cycle after address presented
// BEHAVIOUR
//  - States: IDLE, WRITE, READ, RESP. req_ready = (state==IDLE). Inputs latched at accept edge.
//  - N = 1/2/4 for funct3[1:0] = 0/1/2; byte k address = (base + k) mod 2**ADDR_WIDTH.
//  - WRITE: N cycles, cycle k drives mem_write_enable=1, addr byte k, data req_wdata[8k+7:8k];
//    then RESP. rsp_valid high N+1 cycles after accept edge; rsp_rdata=0.
//  - READ: N+1 cycles; cycle k (k<N) drives mem_read_address byte k; cycle k+1 captures
//    mem_read_data into rdata[8k+7:8k]. Then RESP with rsp_rdata registered: funct3[2]=0
//    sign-extends from bit 8N-1, funct3[2]=1 zero-extends. rsp_valid N+2 cycles after accept.
//  - RESP: 1 cycle, rsp_valid=1, then IDLE (req_ready=1 next cycle; back-to-back allowed).
//  - Reserved funct3 (3,6,7 loads; >=3 stores): no RAM access, RESP next cycle, rsp_error=1.
//  - mem_write_enable is 0 in every state except WRITE; never asserted during a load.
//  - Address wrap: word at 0x7FF touches 0x7FF,0x000,0x001,0x002.
//  - req_valid outside IDLE is ignored; latched request unaffected by input changes.
//  - Reset (any state): next cycle state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//    rsp_error=0, mem_write_enable=0, both addresses=0, mem_write_data=0. Partially written
//    bytes remain in RAM (no rollback); aborted request produces no response.
// CONFIGURATION
//  MEMORY_WORD_CTRL_ALIGN_CHECK_EN
//   defined: H with addr[0]!=0 or W with addr[1:0]!=0 -> no RAM access, RESP next cycle,
//     rsp_error=1, rsp_rdata=0.
//   undefined: misaligned accesses proceed byte-wise with wrap; rsp_error only for reserved funct3.
// TESTING
//  1. SW 0xDEADBEEF @0x010 then LW @0x010 -> rsp 5 cycles after SW accept, LW rsp 6 cycles
//     after accept, rdata 0xDEADBEEF, error 0; RAM[0x010..0x013]=EF,BE,AD,DE.
//  2. After 1: LB @0x013 -> 0xFFFFFFDE; LBU @0x013 -> 0x000000DE; LH @0x012 -> 0xFFFFDEAD;
//     LHU @0x010 -> 0x0000BEEF.
//  3. SW 0x11223344 @0x7FC then SB 0xA5 @0x7FF, LW @0x7FC -> 0xA5223344; SW @0x7FF writes 0x000.
//  4. Load funct3=3 and store funct3=4 -> rsp_valid 2 cycles after accept, error 1,
//     mem_write_enable never high, RAM unchanged.
//  5. SW 0xCAFEF00D @0x020 with reset asserted during 3rd WRITE cycle -> RAM[0x020]=0D,
//     [0x021]=F0, [0x022..0x023] unchanged, no rsp_valid, req_ready=1 cycle after reset edge.
//  6. LW @0x011: with ALIGN_CHECK_EN -> error 1, no RAM read; without -> bytes 0x011..0x014
//     assembled little-endian, error 0.

Source files
------------

// File: rtl/memory_word_if.sv
// memory_word_if: load/store request and response bundle between the core LSU
// and memory_word_controller.
interface memory_word_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/memory_word_controller.sv
// memory_word_controller: RV32 LB/LH/LW/LBU/LHU/SB/SH/SW port sequenced onto a byte-wide sync RAM.
// Optional macro MEMORY_WORD_CTRL_ALIGN_CHECK_EN rejects misaligned H/W accesses with rsp_error.
module memory_word_controller #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  memory_word_if.slave          bus,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [7:0]            mem_write_data,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [7:0]            mem_read_data
);
  // state | meaning
  // IDLE  | req_ready high, waiting for a request
  // WRITE | one store byte per cycle
  // READ  | byte addresses out, data captured a cycle later; also the one-cycle error stall
  // RESP  | single rsp_valid pulse
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
  state_t state_q, state_d;

  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [2:0]            cnt_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic [31:0]           rsp_rdata_q;
  logic                  rsp_error_q;

  logic                  req_fire;
  logic                  req_bad;
  logic [2:0]            n_bytes;
  logic [ADDR_WIDTH-1:0] byte_addr;
  logic [7:0]            wbyte;
  logic [31:0]           rdata_full;
  logic [31:0]           rdata_ext;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr[31:ADDR_WIDTH];
  assign req_fire         = bus.req_valid && (state_q == IDLE);
  assign byte_addr        = base_q + ADDR_WIDTH'(cnt_q);

  always_comb begin
    if (bus.req_write)
      req_bad = (bus.req_funct3 > 3'd2);
    else
      req_bad = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) || (bus.req_funct3 == 3'd7);
`ifdef MEMORY_WORD_CTRL_ALIGN_CHECK_EN
    if ((bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0]) ||
        (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'd0))
      req_bad = 1'b1;
`endif
  end

  always_comb begin
    case (funct3_q[1:0])
      2'd0:    n_bytes = 3'd1;
      2'd1:    n_bytes = 3'd2;
      default: n_bytes = 3'd4;
    endcase
  end

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
  end

  // Byte k arrives while cnt_q == k+1; merge it so the last byte needs no extra cycle.
  always_comb begin
    rdata_full = rdata_q;
    case (cnt_q)
      3'd1:    rdata_full[7:0]   = mem_read_data;
      3'd2:    rdata_full[15:8]  = mem_read_data;
      3'd3:    rdata_full[23:16] = mem_read_data;
      3'd4:    rdata_full[31:24] = mem_read_data;
      default: ;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'd0:    rdata_ext = funct3_q[2] ? {24'd0, rdata_full[7:0]}
                                       : {{24{rdata_full[7]}}, rdata_full[7:0]};
      2'd1:    rdata_ext = funct3_q[2] ? {16'd0, rdata_full[15:0]}
                                       : {{16{rdata_full[15]}}, rdata_full[15:0]};
      default: rdata_ext = rdata_full;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    bus.req_ready     = (state_q == IDLE);
    bus.rsp_valid     = (state_q == RESP);
    bus.rsp_rdata     = (state_q == RESP) ? rsp_rdata_q : 32'd0;
    bus.rsp_error     = (state_q == RESP) && rsp_error_q;
    // Gated by reset so a store aborted mid-sequence writes no further byte.
    mem_write_enable  = (state_q == WRITE) && !reset;
    mem_write_address = '0;
    mem_write_data    = 8'd0;
    mem_read_address  = '0;
    case (state_q)
      IDLE: if (req_fire) state_d = (bus.req_write && !req_bad) ? WRITE : READ;
      WRITE: begin
        mem_write_address = byte_addr;
        mem_write_data    = wbyte;
        if (cnt_q == n_bytes - 3'd1) state_d = RESP;
      end
      READ: begin
        if (!err_q && cnt_q < n_bytes) mem_read_address = byte_addr;
        if (err_q || cnt_q == n_bytes) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      funct3_q    <= 3'd0;
      base_q      <= '0;
      wdata_q     <= 32'd0;
      cnt_q       <= 3'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_fire) begin
          funct3_q <= bus.req_funct3;
          base_q   <= bus.req_addr[ADDR_WIDTH-1:0];
          wdata_q  <= bus.req_wdata;
          cnt_q    <= 3'd0;
          rdata_q  <= 32'd0;
          err_q    <= req_bad;
        end
        WRITE: begin
          cnt_q <= cnt_q + 3'd1;
          if (state_d == RESP) begin
            rsp_rdata_q <= 32'd0;
            rsp_error_q <= 1'b0;
          end
        end
        READ: begin
          rdata_q <= rdata_full;
          cnt_q   <= cnt_q + 3'd1;
          if (state_d == RESP) begin
            rsp_rdata_q <= err_q ? 32'd0 : rdata_ext;
            rsp_error_q <= err_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
